// File: rtl/acc_loop_seq.sv
// Accumulator-loop sequencer: streams the input buffer into an INTT, then iterates INTT/DECOMP/NTT/FEED and captures the final NTT output.
// Optional watchdog on the INTT/NTT waits: define ACC_LOOP_TIMEOUT_EN.
module acc_loop_seq #(
  parameter int DATA_W      = 32,
  parameter int RING_DEPTH  = 10,
  parameter int PE_DEPTH    = 3,
  parameter int STAGE_DELAY = 4,
  parameter int ITER_W      = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_we,
  input  logic [RING_DEPTH-1:0] in_waddr,
  input  logic [DATA_W-1:0]     in_wdata,
  input  logic                  start,
  input  logic [ITER_W-1:0]     num_iter,
  output logic                  busy,
  output logic                  done,
  output logic [ITER_W-1:0]     iter_cnt,
  output logic                  intt_load,
  output logic [DATA_W-1:0]     intt_din,
  output logic                  intt_start,
  input  logic                  intt_done,
  output logic                  ntt_load,
  output logic                  ntt_start,
  output logic                  ntt_out_sel,
  input  logic                  ntt_done,
  input  logic [DATA_W-1:0]     ntt_dout,
  input  logic [RING_DEPTH-1:0] out_raddr,
  output logic [DATA_W-1:0]     out_rdata,
  output logic                  err
);

  localparam int N  = 1 << RING_DEPTH;
  localparam int CW = RING_DEPTH + 4;
  localparam logic [CW-1:0] N_C    = CW'(N);
  localparam logic [CW-1:0] D_M1_C = CW'(N / (2 ** (PE_DEPTH + 1)) + STAGE_DELAY - 1);
`ifdef ACC_LOOP_TIMEOUT_EN
  localparam logic [CW-1:0] TMO_C  = CW'((1 << (RING_DEPTH + 3)) - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_INTT, S_DECOMP, S_NTT, S_FEED, S_OUT
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [ITER_W-1:0]   iter_cnt_q, iter_cnt_d;
  logic [ITER_W-1:0]   num_iter_q, num_iter_d;
  logic                done_zero_q, done_zero_d;
  logic                ntt_load_q, ntt_load_d;
  logic                timeout;
  logic                out_we;

  logic [DATA_W-1:0]   in_mem  [N];
  logic [DATA_W-1:0]   out_mem [N];
  logic [DATA_W-1:0]   in_rdata_q;
  logic [DATA_W-1:0]   out_rdata_q;

  // Buffers carry no reset so they map onto block RAM and survive reset.
  always_ff @(posedge clk) begin
    if (in_we) in_mem[in_waddr] <= in_wdata;
    in_rdata_q <= in_mem[cnt_q[RING_DEPTH-1:0]];
  end

  always_ff @(posedge clk) begin
    if (out_we) out_mem[cnt_q[RING_DEPTH-1:0]] <= ntt_dout;
    out_rdata_q <= out_mem[out_raddr];
  end

`ifdef ACC_LOOP_TIMEOUT_EN
  assign timeout = (cnt_q == TMO_C);
  assign err     = timeout && (((state_q == S_INTT) && !intt_done) ||
                               ((state_q == S_NTT) && !ntt_done));
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
    iter_cnt_d  = iter_cnt_q;
    num_iter_d  = num_iter_q;
    done_zero_d = 1'b0;
    ntt_load_d  = intt_done;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          if (num_iter != '0) begin
            state_d    = S_LOAD;
            iter_cnt_d = '0;
            num_iter_d = num_iter;
          end else begin
            done_zero_d = 1'b1;
          end
        end
      end
      // LOAD and OUT occupy cnt 0..N; DECOMP and FEED occupy cnt 0..D-1.
      S_LOAD:   if (cnt_q == N_C) state_d = S_INTT;
      S_INTT: begin
        if (intt_done)    state_d = S_DECOMP;
        else if (timeout) state_d = S_IDLE;
      end
      S_DECOMP: if (cnt_q == D_M1_C) state_d = S_NTT;
      S_NTT: begin
        if (ntt_done) begin
          iter_cnt_d = iter_cnt_q + ITER_W'(1);
          state_d    = (iter_cnt_d == num_iter_q) ? S_OUT : S_FEED;
        end else if (timeout) begin
          state_d = S_IDLE;
        end
      end
      S_FEED:   if (cnt_q == D_M1_C) state_d = S_INTT;
      S_OUT:    if (cnt_q == N_C) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      iter_cnt_q  <= '0;
      num_iter_q  <= '0;
      done_zero_q <= 1'b0;
      ntt_load_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      iter_cnt_q  <= iter_cnt_d;
      num_iter_q  <= num_iter_d;
      done_zero_q <= done_zero_d;
      ntt_load_q  <= ntt_load_d;
    end
  end

  // Strobes decode from state so an asynchronous reset drops them at once.
  assign out_we      = (state_q == S_OUT) && (cnt_q < N_C);
  assign busy        = (state_q != S_IDLE);
  assign done        = done_zero_q || ((state_q == S_OUT) && (cnt_q == N_C));
  assign iter_cnt    = iter_cnt_q;
  assign intt_load   = (state_q == S_LOAD) && (cnt_q == CW'(1));
  assign intt_din    = ((state_q == S_LOAD) && (cnt_q != '0) && (cnt_q <= N_C)) ? in_rdata_q : '0;
  assign intt_start  = (state_q == S_INTT) && (cnt_q == CW'(1));
  assign ntt_start   = (state_q == S_NTT) && (cnt_q == CW'(1));
  assign ntt_load    = ntt_load_q;
  assign ntt_out_sel = (state_q == S_OUT) ||
                       ((state_q == S_NTT) && (iter_cnt_q == num_iter_q - ITER_W'(1)));
  assign out_rdata   = out_rdata_q;

endmodule

// File: tb/tb_acc_loop_seq.sv
// Directed bench for acc_loop_seq: stubbed INTT/NTT, event-time queues and an expected-value scoreboard.
module tb_acc_loop_seq;
  localparam int DW = 32;
  localparam int RD = 4;
  localparam int IW = 10;
  localparam int N  = 16;
  localparam int D  = 6;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_we = 1'b0;
  logic [RD-1:0] in_waddr = '0;
  logic [DW-1:0] in_wdata = '0;
  logic          start = 1'b0;
  logic [IW-1:0] num_iter = '0;
  logic          busy, done, intt_load, intt_start, ntt_load, ntt_start, ntt_out_sel, err;
  logic [IW-1:0] iter_cnt;
  logic [DW-1:0] intt_din, out_rdata;
  logic          intt_done = 1'b0;
  logic          ntt_done = 1'b0;
  logic [DW-1:0] ntt_dout = '0;
  logic [RD-1:0] out_raddr = '0;

  acc_loop_seq #(
    .DATA_W(DW), .RING_DEPTH(RD), .PE_DEPTH(1), .STAGE_DELAY(2), .ITER_W(IW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_we(in_we), .in_waddr(in_waddr), .in_wdata(in_wdata),
    .start(start), .num_iter(num_iter), .busy(busy), .done(done), .iter_cnt(iter_cnt),
    .intt_load(intt_load), .intt_din(intt_din), .intt_start(intt_start), .intt_done(intt_done),
    .ntt_load(ntt_load), .ntt_start(ntt_start), .ntt_out_sel(ntt_out_sel), .ntt_done(ntt_done),
    .ntt_dout(ntt_dout), .out_raddr(out_raddr), .out_rdata(out_rdata), .err(err)
  );

  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            intt_cd = 0, ntt_cd = 0, dout_k = 0, din_left = 0;
  bit            withhold = 1'b0;
  int            intt_start_q[$], ntt_start_q[$], intt_done_q[$], ntt_done_q[$];
  int            ntt_load_q[$], done_q[$], err_q[$];
  bit            sel_q[$];
  logic [DW-1:0] din_obs[$];
  logic [DW-1:0] din_exp[$];
  logic [DW-1:0] exp_out[N];

  // Stub INTT/NTT (done 20 cycles after start, dout = 0x100 + cycles since ntt_done) and event recorder.
  always @(negedge clk) begin
    cyc++;
    if (ntt_done) dout_k = 0;
    else dout_k++;
    ntt_dout  = 32'(32'h100 + dout_k);
    intt_done = 1'b0;
    ntt_done  = 1'b0;
    if (!reset_n) begin
      intt_cd  = 0;
      ntt_cd   = 0;
      din_left = 0;
    end else begin
      if (intt_cd > 0) begin
        intt_cd--;
        if (intt_cd == 0) begin intt_done = 1'b1; intt_done_q.push_back(cyc); end
      end
      if (ntt_cd > 0) begin
        ntt_cd--;
        if (ntt_cd == 0) begin ntt_done = 1'b1; ntt_done_q.push_back(cyc); end
      end
      if (intt_load) din_left = N;
      if (din_left > 0) begin din_obs.push_back(intt_din); din_left--; end
      if (intt_start) begin
        intt_start_q.push_back(cyc);
        if (!withhold) intt_cd = 20;
      end
      if (ntt_start) begin
        ntt_start_q.push_back(cyc);
        sel_q.push_back(ntt_out_sel);
        ntt_cd = 20;
      end
      if (ntt_load) ntt_load_q.push_back(cyc);
      if (done) done_q.push_back(cyc);
      if (err) err_q.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic readback(input string tag);
    logic [DW-1:0] sb[$];
    for (int k = 0; k <= N; k++) begin
      if (k > 0) chk(tag, 64'(out_rdata), 64'(sb.pop_front()));
      if (k < N) begin
        out_raddr = RD'(k);
        sb.push_back(exp_out[k]);
      end
      step();
    end
  endtask

  task automatic check_din(input int base, input string tag);
    chk({tag, "_din_count"}, 64'(din_obs.size() - base), 64'(N));
    for (int k = 0; k < N && base + k < din_obs.size(); k++)
      chk({tag, "_din"}, 64'(din_obs[base + k]), 64'(din_exp.pop_front()));
    din_exp.delete();
  endtask

  task automatic run(input int niter, input bit glitch);
    int b_is, b_ns, b_id, b_nd, b_nl, b_dn, b_din, st;
    bit counts_ok;
    b_is = intt_start_q.size(); b_ns = ntt_start_q.size(); b_id = intt_done_q.size();
    b_nd = ntt_done_q.size();   b_nl = ntt_load_q.size();  b_dn = done_q.size();
    b_din = din_obs.size();
    for (int k = 0; k < N; k++) din_exp.push_back(32'(k + 1));
    start = 1'b1; num_iter = IW'(niter); st = cyc;
    step();
    start = 1'b0;
    if (glitch) begin
      for (int i = 0; i < 200 && ntt_start_q.size() == b_ns; i++) step();
      start = 1'b1; num_iter = IW'(7);
      step();
      start = 1'b0;
    end
    for (int i = 0; i < 2000 && done_q.size() == b_dn; i++) step();
    repeat (3) step();
    $display("run niter=%0d glitch=%0d: start@%0d done pulses=%0d iter_cnt=%0d", niter, glitch, st,
             done_q.size() - b_dn, iter_cnt);
    chk("run_done_pulses", 64'(done_q.size() - b_dn), 64'(1));
    chk("run_busy_after", 64'(busy), 64'(0));
    chk("run_iter_cnt", 64'(iter_cnt), 64'(niter));
    chk("run_intt_starts", 64'(intt_start_q.size() - b_is), 64'(niter));
    chk("run_ntt_starts", 64'(ntt_start_q.size() - b_ns), 64'(niter));
    counts_ok = (intt_start_q.size() - b_is == niter) && (ntt_start_q.size() - b_ns == niter) &&
                (intt_done_q.size() - b_id == niter) && (ntt_done_q.size() - b_nd == niter) &&
                (ntt_load_q.size() - b_nl == niter) && (done_q.size() > b_dn);
    chk("run_event_counts", 64'(counts_ok), 64'(1));
    if (counts_ok) begin
      chk("load_to_intt_start", 64'(intt_start_q[b_is] - st), 64'(N + 3));
      for (int i = 0; i < niter; i++) begin
        chk("ntt_load_lag", 64'(ntt_load_q[b_nl + i] - intt_done_q[b_id + i]), 64'(1));
        chk("decomp_gap", 64'(ntt_start_q[b_ns + i] - intt_done_q[b_id + i]), 64'(D + 2));
        chk("ntt_out_sel", 64'(sel_q[b_ns + i]), 64'(i == niter - 1));
        if (i > 0)
          chk("feed_gap", 64'(intt_start_q[b_is + i] - ntt_done_q[b_nd + i - 1]), 64'(D + 2));
      end
      chk("out_done_lag", 64'(done_q[b_dn] - ntt_done_q[b_nd + niter - 1]), 64'(N + 1));
    end
    check_din(b_din, "run");
    for (int k = 0; k < N; k++) exp_out[k] = 32'(32'h100 + k);
    readback("run_out");
  endtask

  initial begin
    int b_nd, b_din, b_is, b_err, b_dn;
    // Reset state.
    repeat (3) step();
    chk("rst_ctrl", 64'({busy, done, err, intt_load, intt_start, ntt_load, ntt_start, ntt_out_sel}), 64'd0);
    chk("rst_iter_cnt", 64'(iter_cnt), 64'd0);
    chk("rst_intt_din", 64'(intt_din), 64'd0);
    reset_n = 1'b1;
    step();
    for (int k = 0; k < N; k++) begin
      in_we = 1'b1; in_waddr = RD'(k); in_wdata = 32'(k + 1);
      step();
    end
    in_we = 1'b0;

    run(1, 1'b0);
    run(3, 1'b0);

    // num_iter == 0: done the next cycle, no busy, output buffer untouched.
    start = 1'b1; num_iter = '0;
    step();
    start = 1'b0;
    $display("zero-iteration start: done=%0d busy=%0d", done, busy);
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_busy", 64'(busy), 64'd0);
    step();
    chk("zero_done_clear", 64'(done), 64'd0);
    chk("zero_busy_later", 64'(busy), 64'd0);
    readback("zero_out");

    run(2, 1'b1);

    // Asynchronous reset at FEED cnt=3 of a three-iteration run.
    b_nd = ntt_done_q.size(); b_din = din_obs.size();
    for (int k = 0; k < N; k++) din_exp.push_back(32'(k + 1));
    start = 1'b1; num_iter = IW'(3);
    step();
    start = 1'b0;
    for (int i = 0; i < 200 && ntt_done_q.size() == b_nd; i++) step();
    repeat (4) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    $display("mid-run reset applied at cycle %0d", cyc);
    chk("mrst_ctrl", 64'({busy, done, err, intt_load, intt_start, ntt_load, ntt_start, ntt_out_sel}), 64'd0);
    chk("mrst_iter_cnt", 64'(iter_cnt), 64'd0);
    chk("mrst_intt_din", 64'(intt_din), 64'd0);
    check_din(b_din, "mrst");
    repeat (2) step();
    reset_n = 1'b1;
    step();
    run(1, 1'b0);

    // Withheld intt_done: watchdog behaviour depends on the build.
    withhold = 1'b1;
    b_is = intt_start_q.size(); b_err = err_q.size(); b_dn = done_q.size();
    start = 1'b1; num_iter = IW'(1);
    step();
    start = 1'b0;
    for (int i = 0; i < 100 && intt_start_q.size() == b_is; i++) step();
    chk("wd_intt_start", 64'(intt_start_q.size() - b_is), 64'd1);
    repeat (200) step();
    $display("withheld intt_done: err pulses=%0d busy=%0d", err_q.size() - b_err, busy);
`ifdef ACC_LOOP_TIMEOUT_EN
    chk("wd_err_pulses", 64'(err_q.size() - b_err), 64'd1);
    if (err_q.size() > b_err && intt_start_q.size() > b_is)
      chk("wd_err_time", 64'(err_q[b_err] - intt_start_q[b_is]), 64'd126);
    chk("wd_busy", 64'(busy), 64'd0);
    chk("wd_no_done", 64'(done_q.size() - b_dn), 64'd0);
`else
    chk("wd_err_pulses", 64'(err_q.size() - b_err), 64'd0);
    chk("wd_busy", 64'(busy), 64'd1);
    chk("wd_no_done", 64'(done_q.size() - b_dn), 64'd0);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
`endif
    withhold = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
